xdma_usr_irq_ctrl: RTL



---
 rtl/xdma_usr_irq_ctrl_pkg.sv | 24 ++
 rtl/xdma_usr_irq_ctrl_if.sv | 25 ++
 rtl/xdma_usr_irq_chan.sv | 109 ++++++++++
 rtl/xdma_usr_irq_ctrl.sv | 42 ++++
 4 files changed

// File: rtl/xdma_usr_irq_ctrl_pkg.sv
// Shared types and constants for the XDMA user interrupt controller.
package pcie_irq_pkg;

    // Per-vector handshake state.
    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_HOLDOFF = 2'd2
    } irq_state_e;

    localparam int DEF_NUM_VEC     = 4;
    localparam int DEF_HOLDOFF_CYC = 16;
    localparam int DEF_ACK_TIMEOUT = 4096;
    localparam int DEF_CNT_W       = 8;

    // One timer serves both the ack wait (counts up to ACK_TIMEOUT-1) and the
    // holdoff (counts down from HOLDOFF_CYC-1), so it is sized for the larger.
    function automatic int timer_width(input int holdoff_cyc, input int ack_timeout);
        int max_cyc;
        max_cyc = (holdoff_cyc > ack_timeout) ? holdoff_cyc : ack_timeout;
        return (max_cyc > 1) ? $clog2(max_cyc) : 1;
    endfunction

endpackage

// File: rtl/xdma_usr_irq_ctrl_if.sv
// XDMA user interrupt handshake: level request out, one-cycle ack back,
// plus the MSI enable that gates new requests.
interface xdma_usr_irq_ctrl_if
    import pcie_irq_pkg::*;
#(
    parameter int NUM_VEC = DEF_NUM_VEC
);
    logic [NUM_VEC-1:0] usr_irq_req;
    logic [NUM_VEC-1:0] usr_irq_ack;
    logic               msi_enable;

    // Interrupt controller side.
    modport master (
        output usr_irq_req,
        input  usr_irq_ack,
        input  msi_enable
    );

    // XDMA core side.
    modport slave (
        input  usr_irq_req,
        output usr_irq_ack,
        output msi_enable
    );
endinterface

// File: rtl/xdma_usr_irq_chan.sv
// One interrupt vector: event capture, coalescing counter, request/ack FSM
// with ack timeout and post-request holdoff, sticky timeout flag.
module xdma_usr_irq_chan
    import pcie_irq_pkg::*;
#(
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt,
    input  logic             mask,
    input  logic             msi_enable,
    input  logic             ack,
    input  logic             err_clr,
    output logic             req,
    output logic             pending,
    output logic [CNT_W-1:0] coal_cnt,
    output logic             timeout_err
);

    localparam int TMR_W = timer_width(HOLDOFF_CYC, ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_TO_LAST   = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_HOLD_LOAD = TMR_W'(HOLDOFF_CYC - 1);

    irq_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             issue;

    // A fresh event is visible to the IDLE decision in its own cycle, which
    // gives the one-cycle event-to-request latency.
    assign issue = (pending_q || evt) && !mask && msi_enable;

    // Next-state, timer, pending, coalescing and error-flag logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q || evt;
        cnt_d     = (evt && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
        err_d     = err_clr ? 1'b0 : err_q;

        unique case (state_q)
            IRQ_IDLE: begin
                if (issue) begin
                    state_d   = IRQ_REQ;
                    timer_d   = '0;
                    // An event landing on top of an already pending one
                    // earns a further request; otherwise it is consumed here.
                    pending_d = pending_q && evt;
                end
            end
            IRQ_REQ: begin
                if (ack) begin
                    state_d = IRQ_HOLDOFF;
                    timer_d = TMR_HOLD_LOAD;
                    cnt_d   = evt ? CNT_W'(1) : '0;
                end else if (timer_q == TMR_TO_LAST) begin
                    state_d   = IRQ_HOLDOFF;
                    timer_d   = TMR_HOLD_LOAD;
                    pending_d = 1'b1;
                    // Set beats a simultaneous clear.
                    err_d     = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            IRQ_HOLDOFF: begin
                if (timer_q == '0) begin
                    state_d = IRQ_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q   <= IRQ_IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign req         = (state_q == IRQ_REQ);
    assign pending     = pending_q;
    assign coal_cnt    = cnt_q;
    assign timeout_err = err_q;

endmodule

// File: rtl/xdma_usr_irq_ctrl.sv
// User interrupt controller in front of the xdma_0 usr_irq port: one
// independent channel per vector, outputs concatenated by vector index.
module xdma_usr_irq_ctrl
    import pcie_irq_pkg::*;
#(
    parameter int NUM_VEC     = DEF_NUM_VEC,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_VEC-1:0]       evt_i,
    input  logic [NUM_VEC-1:0]       mask_i,
    input  logic [NUM_VEC-1:0]       err_clr_i,
    output logic [NUM_VEC-1:0]       irq_pending_o,
    output logic [NUM_VEC*CNT_W-1:0] coal_cnt_o,
    output logic [NUM_VEC-1:0]       timeout_err_o,
    xdma_usr_irq_ctrl_if.master      irq_if
);

    for (genvar v = 0; v < NUM_VEC; v++) begin : g_chan
        xdma_usr_irq_chan #(
            .HOLDOFF_CYC (HOLDOFF_CYC),
            .ACK_TIMEOUT (ACK_TIMEOUT),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .evt         (evt_i[v]),
            .mask        (mask_i[v]),
            .msi_enable  (irq_if.msi_enable),
            .ack         (irq_if.usr_irq_ack[v]),
            .err_clr     (err_clr_i[v]),
            .req         (irq_if.usr_irq_req[v]),
            .pending     (irq_pending_o[v]),
            .coal_cnt    (coal_cnt_o[v*CNT_W +: CNT_W]),
            .timeout_err (timeout_err_o[v])
        );
    end

endmodule
